// File: rtl/dmem_arbiter_pkg.sv
// Shared types for the data-memory arbiter.
// Owner encoding and the in-flight read tag.
package dmem_arbiter_pkg;

  typedef enum logic {
    OWN_CORE = 1'b0,
    OWN_DBG  = 1'b1
  } dmem_owner_t;

  typedef struct packed {
    logic        valid;
    dmem_owner_t owner;
    logic        err;
  } dmem_tag_t;

endpackage

// File: rtl/dmem_tag_pipe.sv
// MEM_LATENCY-deep shift register of read tags.
// Ports: i_clock, i_reset_n, i_tag (push), o_tag (oldest stage).
module dmem_tag_pipe
  import dmem_arbiter_pkg::*;
#(
  parameter int MEM_LATENCY = 1
) (
  input  logic      i_clock,
  input  logic      i_reset_n,
  input  dmem_tag_t i_tag,
  output dmem_tag_t o_tag
);

  dmem_tag_t stage [MEM_LATENCY];

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      for (int i = 0; i < MEM_LATENCY; i++) begin
        stage[i] <= '0;
      end
    end else begin
      stage[0] <= i_tag;
      for (int i = 1; i < MEM_LATENCY; i++) begin
        stage[i] <= stage[i-1];
      end
    end
  end

  assign o_tag = stage[MEM_LATENCY-1];

endmodule

// File: rtl/dmem_arbiter.sv
// Core/debug arbiter for the single-port data memory.
// Ports: core and debug request ports, memory command, memory read data.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int MEM_LATENCY  = 1,
  parameter int DEPTH_WORDS  = 1024,
  parameter int STARVE_LIMIT = 8,
  localparam int AW = $clog2(DEPTH_WORDS)
) (
  input  logic          i_clock,
  input  logic          i_reset_n,
  input  logic          i_core_req,
  input  logic          i_core_we,
  input  logic [31:0]   i_core_addr,
  input  logic [31:0]   i_core_wdata,
  input  logic [3:0]    i_core_be,
  output logic          o_core_gnt,
  output logic          o_core_rvalid,
  output logic [31:0]   o_core_rdata,
  output logic          o_core_err,
  input  logic          i_dbg_req,
  input  logic          i_dbg_we,
  input  logic [31:0]   i_dbg_addr,
  input  logic [31:0]   i_dbg_wdata,
  input  logic [3:0]    i_dbg_be,
  output logic          o_dbg_gnt,
  output logic          o_dbg_rvalid,
  output logic [31:0]   o_dbg_rdata,
  output logic          o_dbg_err,
  output logic          o_mem_en,
  output logic          o_mem_we,
  output logic [AW-1:0] o_mem_addr,
  output logic [31:0]   o_mem_wdata,
  output logic [3:0]    o_mem_be,
  input  logic [31:0]   i_mem_rdata
);

  localparam int CW = $clog2(STARVE_LIMIT + 1);

  logic [CW-1:0] starve_cnt;
  logic          starved;
  logic          core_gnt;
  logic          dbg_gnt;
  logic          any_gnt;
  logic          sel_we;
  logic [31:0]   sel_addr;
  logic [31:0]   sel_wdata;
  logic [3:0]    sel_be;
  logic [29:0]   idx;
  logic          in_range;
  logic          mem_en;
  dmem_tag_t     tag_in;
  dmem_tag_t     tag_out;
  logic          ret;
  logic [31:0]   ret_data;
  logic          unused_bits;

  assign starved = (starve_cnt == CW'(STARVE_LIMIT));

  always_comb begin
    core_gnt = 1'b0;
    dbg_gnt  = 1'b0;
    if (i_reset_n) begin
      if (i_dbg_req && (!i_core_req || starved)) begin
        dbg_gnt = 1'b1;
      end else if (i_core_req) begin
        core_gnt = 1'b1;
      end
    end
  end

  assign any_gnt   = core_gnt | dbg_gnt;
  assign sel_we    = dbg_gnt ? i_dbg_we    : i_core_we;
  assign sel_addr  = dbg_gnt ? i_dbg_addr  : i_core_addr;
  assign sel_wdata = dbg_gnt ? i_dbg_wdata : i_core_wdata;
  assign sel_be    = dbg_gnt ? i_dbg_be    : i_core_be;

  // Out-of-range accesses are still granted; they just never reach memory.
  assign idx      = sel_addr[31:2];
  assign in_range = idx < 30'(DEPTH_WORDS);
  assign mem_en   = any_gnt & in_range;

  assign o_core_gnt  = core_gnt;
  assign o_dbg_gnt   = dbg_gnt;
  assign o_mem_en    = mem_en;
  assign o_mem_we    = mem_en & sel_we;
  assign o_mem_addr  = mem_en ? idx[AW-1:0] : '0;
  assign o_mem_wdata = mem_en ? sel_wdata : '0;
  assign o_mem_be    = mem_en ? sel_be : '0;

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      starve_cnt <= '0;
    end else if (dbg_gnt) begin
      starve_cnt <= '0;
    end else if (i_dbg_req && !starved) begin
      starve_cnt <= starve_cnt + CW'(1);
    end
  end

  always_comb begin
    tag_in = '0;
    if (any_gnt && !sel_we) begin
      tag_in.valid = 1'b1;
      tag_in.owner = dbg_gnt ? OWN_DBG : OWN_CORE;
      tag_in.err   = !in_range;
    end
  end

  dmem_tag_pipe #(
    .MEM_LATENCY(MEM_LATENCY)
  ) u_tag_pipe (
    .i_clock  (i_clock),
    .i_reset_n(i_reset_n),
    .i_tag    (tag_in),
    .o_tag    (tag_out)
  );

  assign ret      = tag_out.valid & i_reset_n;
  assign ret_data = (ret && !tag_out.err) ? i_mem_rdata : '0;

  assign o_core_rvalid = ret & (tag_out.owner == OWN_CORE);
  assign o_dbg_rvalid  = ret & (tag_out.owner == OWN_DBG);
  assign o_core_rdata  = o_core_rvalid ? ret_data : '0;
  assign o_dbg_rdata   = o_dbg_rvalid ? ret_data : '0;
  assign o_core_err    = o_core_rvalid & tag_out.err;
  assign o_dbg_err     = o_dbg_rvalid & tag_out.err;

  assign unused_bits = ^{i_core_addr[1:0], i_dbg_addr[1:0], idx[29:AW]};

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter at MEM_LATENCY 1, 3 and 2.
// All three instances share stimulus; each has its own memory model.
module tb_dmem_arbiter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic load = 1'b0;

  logic        core_req, core_we, dbg_req, dbg_we;
  logic [31:0] core_addr, core_wdata, dbg_addr, dbg_wdata;
  logic [3:0]  core_be, dbg_be;

  logic        cg [3];
  logic        crv [3];
  logic        cer [3];
  logic [31:0] crd [3];
  logic        dg [3];
  logic        drv [3];
  logic        der [3];
  logic [31:0] drd [3];
  logic        men [3];
  logic        mwe [3];
  logic [5:0]  ma [3];
  logic [31:0] mwd [3];
  logic [3:0]  mbe [3];
  logic [31:0] mrd [3];

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : gi
    localparam int LAT = (g == 0) ? 1 : ((g == 1) ? 3 : 2);
    logic [31:0] mem [64];
    logic [31:0] rp [4];

    dmem_arbiter #(
      .MEM_LATENCY (LAT),
      .DEPTH_WORDS (64),
      .STARVE_LIMIT(8)
    ) dut (
      .i_clock      (clk),
      .i_reset_n    (rst_n),
      .i_core_req   (core_req),
      .i_core_we    (core_we),
      .i_core_addr  (core_addr),
      .i_core_wdata (core_wdata),
      .i_core_be    (core_be),
      .o_core_gnt   (cg[g]),
      .o_core_rvalid(crv[g]),
      .o_core_rdata (crd[g]),
      .o_core_err   (cer[g]),
      .i_dbg_req    (dbg_req),
      .i_dbg_we     (dbg_we),
      .i_dbg_addr   (dbg_addr),
      .i_dbg_wdata  (dbg_wdata),
      .i_dbg_be     (dbg_be),
      .o_dbg_gnt    (dg[g]),
      .o_dbg_rvalid (drv[g]),
      .o_dbg_rdata  (drd[g]),
      .o_dbg_err    (der[g]),
      .o_mem_en     (men[g]),
      .o_mem_we     (mwe[g]),
      .o_mem_addr   (ma[g]),
      .o_mem_wdata  (mwd[g]),
      .o_mem_be     (mbe[g]),
      .i_mem_rdata  (mrd[g])
    );

    always_ff @(posedge clk) begin
      if (load) begin
        for (int i = 0; i < 64; i++) mem[i] <= 32'h11 * (i + 1);
      end else if (men[g] && mwe[g]) begin
        for (int b = 0; b < 4; b++)
          if (mbe[g][b]) mem[ma[g]][8*b +: 8] <= mwd[g][8*b +: 8];
      end
      if (men[g] && !mwe[g]) rp[0] <= mem[ma[g]];
      for (int k = 1; k < 4; k++) rp[k] <= rp[k-1];
    end

    assign mrd[g] = rp[LAT-1];
  end

  typedef struct {
    logic        creq, cwe;
    logic [31:0] caddr, cwd;
    logic [3:0]  cbe;
    logic        dreq, dwe;
    logic [31:0] daddr, dwd;
    logic [3:0]  dbe;
    logic        ecg, edg, een, ewe;
    logic [5:0]  ea;
    logic [31:0] ewd;
    logic [3:0]  ebe;
  } vec_t;

  vec_t tbl [8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_core(input logic r, input logic w, input logic [31:0] a,
                          input logic [31:0] d, input logic [3:0] b);
    core_req = r; core_we = w; core_addr = a; core_wdata = d; core_be = b;
  endtask

  task automatic set_dbg(input logic r, input logic w, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] b);
    dbg_req = r; dbg_we = w; dbg_addr = a; dbg_wdata = d; dbg_be = b;
  endtask

  task automatic idle(input int n);
    set_core(1'b0, 1'b0, '0, '0, '0);
    set_dbg(1'b0, 1'b0, '0, '0, '0);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    set_core(1'b1, 1'b0, 32'hC, '0, 4'hF);
    set_dbg(1'b1, 1'b0, 32'h8, '0, 4'hF);
    #12;
    for (int g = 0; g < 3; g++) begin
      chk($sformatf("rst_cgnt%0d", g), 32'(cg[g]), 0);
      chk($sformatf("rst_dgnt%0d", g), 32'(dg[g]), 0);
      chk($sformatf("rst_men%0d", g), 32'(men[g]), 0);
      chk($sformatf("rst_crv%0d", g), 32'(crv[g] | drv[g]), 0);
      chk($sformatf("rst_rd%0d", g), crd[g] | drd[g], 0);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    load = 1'b1;
    idle(1);
    load = 1'b0;

    // Core-only reads of words 0..3, latency 1.
    for (int i = 0; i < 5; i++) begin
      if (i < 4) set_core(1'b1, 1'b0, 32'(4 * i), '0, 4'hF);
      else set_core(1'b0, 1'b0, '0, '0, '0);
      @(negedge clk);
      if (i < 4) chk($sformatf("seqA_gnt%0d", i), 32'(cg[0]), 1);
      if (i > 0) begin
        chk($sformatf("seqA_rv%0d", i), 32'(crv[0]), 1);
        chk($sformatf("seqA_rd%0d", i), crd[0], 32'h11 * i);
        chk($sformatf("seqA_drv%0d", i), 32'(drv[0]), 0);
      end
      step();
    end
    idle(4);

    tbl[0] = '{1'b0, 1'b0, '0, '0, '0, 1'b0, 1'b0, '0, '0, '0,
               1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0};
    tbl[1] = '{1'b1, 1'b0, 32'h8, '0, 4'hF, 1'b0, 1'b0, '0, '0, '0,
               1'b1, 1'b0, 1'b1, 1'b0, 6'd2, '0, 4'hF};
    tbl[2] = '{1'b1, 1'b1, 32'h20, 32'hA5A5A5A5, 4'h3, 1'b0, 1'b0, '0, '0, '0,
               1'b1, 1'b0, 1'b1, 1'b1, 6'd8, 32'hA5A5A5A5, 4'h3};
    tbl[3] = '{1'b0, 1'b0, '0, '0, '0, 1'b1, 1'b0, 32'h14, '0, 4'hF,
               1'b0, 1'b1, 1'b1, 1'b0, 6'd5, '0, 4'hF};
    tbl[4] = '{1'b1, 1'b0, 32'h4, '0, 4'hF, 1'b1, 1'b0, 32'h8, 32'h77, 4'hF,
               1'b1, 1'b0, 1'b1, 1'b0, 6'd1, '0, 4'hF};
    tbl[5] = '{1'b0, 1'b0, '0, '0, '0, 1'b1, 1'b0, 32'h8, 32'h77, 4'hF,
               1'b0, 1'b1, 1'b1, 1'b0, 6'd2, 32'h77, 4'hF};
    tbl[6] = '{1'b1, 1'b0, 32'h100, '0, 4'hF, 1'b0, 1'b0, '0, '0, '0,
               1'b1, 1'b0, 1'b0, 1'b0, '0, '0, '0};
    tbl[7] = '{1'b1, 1'b0, 32'h1B, '0, 4'hF, 1'b0, 1'b0, '0, '0, '0,
               1'b1, 1'b0, 1'b1, 1'b0, 6'd6, '0, 4'hF};

    for (int i = 0; i < 8; i++) begin
      set_core(tbl[i].creq, tbl[i].cwe, tbl[i].caddr, tbl[i].cwd, tbl[i].cbe);
      set_dbg(tbl[i].dreq, tbl[i].dwe, tbl[i].daddr, tbl[i].dwd, tbl[i].dbe);
      @(negedge clk);
      for (int g = 0; g < 3; g++) begin
        chk($sformatf("v%0d_cgnt%0d", i, g), 32'(cg[g]), 32'(tbl[i].ecg));
        chk($sformatf("v%0d_dgnt%0d", i, g), 32'(dg[g]), 32'(tbl[i].edg));
        chk($sformatf("v%0d_en%0d", i, g), 32'(men[g]), 32'(tbl[i].een));
        chk($sformatf("v%0d_we%0d", i, g), 32'(mwe[g]), 32'(tbl[i].ewe));
        chk($sformatf("v%0d_addr%0d", i, g), 32'(ma[g]), 32'(tbl[i].ea));
        chk($sformatf("v%0d_wd%0d", i, g), mwd[g], tbl[i].ewd);
        chk($sformatf("v%0d_be%0d", i, g), 32'(mbe[g]), 32'(tbl[i].ebe));
      end
      step();
    end
    idle(4);

    // Both ports request every cycle: debug wins every 9th cycle.
    set_core(1'b1, 1'b0, 32'h0, '0, 4'hF);
    set_dbg(1'b1, 1'b0, 32'h4, '0, 4'hF);
    for (int k = 0; k < 18; k++) begin
      @(negedge clk);
      chk($sformatf("starve_cg%0d", k), 32'(cg[0]), (k % 9 == 8) ? 0 : 1);
      chk($sformatf("starve_dg%0d", k), 32'(dg[0]), (k % 9 == 8) ? 1 : 0);
      step();
    end
    idle(4);

    // Alternating owners at latency 3.
    for (int k = 0; k < 9; k++) begin
      set_core(1'b0, 1'b0, '0, '0, '0);
      set_dbg(1'b0, 1'b0, '0, '0, '0);
      if (k < 6) begin
        if (k % 2 == 1) set_dbg(1'b1, 1'b0, 32'(4 * k), '0, 4'hF);
        else set_core(1'b1, 1'b0, 32'(4 * k), '0, 4'hF);
      end
      @(negedge clk);
      if (k >= 3) begin
        chk($sformatf("alt_crv%0d", k), 32'(crv[1]), ((k - 3) % 2 == 0) ? 1 : 0);
        chk($sformatf("alt_drv%0d", k), 32'(drv[1]), ((k - 3) % 2 == 1) ? 1 : 0);
        chk($sformatf("alt_rd%0d", k), ((k - 3) % 2 == 1) ? drd[1] : crd[1],
            32'h11 * (k - 2));
      end else begin
        chk($sformatf("alt_none%0d", k), 32'(crv[1] | drv[1]), 0);
      end
      step();
    end
    idle(4);

    // Debug write then core read of the same word.
    set_dbg(1'b1, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF);
    @(negedge clk);
    chk("raw_dgnt", 32'(dg[0]), 1);
    step();
    set_dbg(1'b0, 1'b0, '0, '0, '0);
    set_core(1'b1, 1'b0, 32'h10, '0, 4'hF);
    @(negedge clk);
    chk("raw_cgnt", 32'(cg[0]), 1);
    step();
    set_core(1'b0, 1'b0, '0, '0, '0);
    @(negedge clk);
    chk("raw_rv", 32'(crv[0]), 1);
    chk("raw_rd", crd[0], 32'hDEADBEEF);
    step();
    @(negedge clk);
    chk("raw_rd_l2", crd[2], 32'hDEADBEEF);
    idle(4);

    // Out-of-range read and write.
    set_core(1'b1, 1'b0, 32'h100, '0, 4'hF);
    @(negedge clk);
    chk("oor_gnt", 32'(cg[0]), 1);
    chk("oor_en", 32'(men[0]), 0);
    step();
    set_core(1'b1, 1'b1, 32'h100, 32'h12345678, 4'hF);
    @(negedge clk);
    chk("oor_rv", 32'(crv[0]), 1);
    chk("oor_err", 32'(cer[0]), 1);
    chk("oor_rd", crd[0], 0);
    chk("oor_wgnt", 32'(cg[0]), 1);
    chk("oor_wen", 32'(men[0]), 0);
    step();
    set_core(1'b1, 1'b0, 32'h0, '0, 4'hF);
    @(negedge clk);
    chk("oor_wr_norv", 32'(crv[0]), 0);
    step();
    set_core(1'b0, 1'b0, '0, '0, '0);
    @(negedge clk);
    chk("oor_w0_rd", crd[0], 32'h11);
    chk("oor_w0_err", 32'(cer[0]), 0);
    idle(4);

    // Reset with two reads in flight.
    set_core(1'b1, 1'b0, 32'h4, '0, 4'hF);
    step();
    set_core(1'b0, 1'b0, '0, '0, '0);
    set_dbg(1'b1, 1'b0, 32'h8, '0, 4'hF);
    step();
    rst_n = 1'b0;
    set_dbg(1'b0, 1'b0, '0, '0, '0);
    set_core(1'b1, 1'b0, 32'hC, '0, 4'hF);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      for (int g = 0; g < 3; g++) begin
        chk($sformatf("mrst_gnt%0d_%0d", g, k), 32'(cg[g] | dg[g]), 0);
        chk($sformatf("mrst_en%0d_%0d", g, k), 32'(men[g]), 0);
        chk($sformatf("mrst_rv%0d_%0d", g, k), 32'(crv[g] | drv[g]), 0);
        chk($sformatf("mrst_rd%0d_%0d", g, k), crd[g] | drd[g], 0);
      end
      step();
    end
    rst_n = 1'b1;
    set_core(1'b0, 1'b0, '0, '0, '0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      for (int g = 0; g < 3; g++)
        chk($sformatf("post_rv%0d_%0d", g, k), 32'(crv[g] | drv[g]), 0);
      step();
    end
    set_core(1'b1, 1'b0, 32'hC, '0, 4'hF);
    @(negedge clk);
    chk("post_gnt", 32'(cg[2]), 1);
    step();
    set_core(1'b0, 1'b0, '0, '0, '0);
    @(negedge clk);
    chk("post_rv_early", 32'(crv[2]), 0);
    step();
    @(negedge clk);
    chk("post_rv", 32'(crv[2]), 1);
    chk("post_rd", crd[2], 32'h44);
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
